// File: rtl/rom_ctrl_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_ctrl_arb_pkg
// Description : Shared types and constants for the rom_ctrl ROM-port arbiter.
//               ROM_CTRL_ARB_SPARSE_FSM_EN selects a 6-bit sparse state
//               encoding; otherwise the state is plain 2-bit binary.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_ctrl_arb_pkg;

    localparam int STALL_CNT_W_DEFAULT = 8;

`ifdef ROM_CTRL_ARB_SPARSE_FSM_EN
    // Every pair of encodings differs in 4 bits, so any single or double
    // upset lands on an unlisted value that decodes as Error.
    localparam int ARB_STATE_W = 6;
    typedef enum logic [ARB_STATE_W-1:0] {
        ST_CHK_OWN  = 6'b101100,
        ST_HANDOVER = 6'b010110,
        ST_BUS_OWN  = 6'b110001,
        ST_ERROR    = 6'b001011
    } arb_state_e;
`else
    localparam int ARB_STATE_W = 2;
    typedef enum logic [ARB_STATE_W-1:0] {
        ST_CHK_OWN  = 2'd0,
        ST_HANDOVER = 2'd1,
        ST_BUS_OWN  = 2'd2,
        ST_ERROR    = 2'd3
    } arb_state_e;
`endif

    localparam arb_state_e ARB_ERROR_ENC = ST_ERROR;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int vbits(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage : rom_ctrl_arb_pkg
`default_nettype wire

// File: rtl/rom_ctrl_arb_stall_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rom_ctrl_arb_stall_cnt
// Description : Saturating event counter; counts cycles with incr_i high and
//               holds at all-ones. Cleared only by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_ctrl_arb_stall_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             incr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (incr_i && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Counter register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : rom_ctrl_arb_stall_cnt
`default_nettype wire

// File: rtl/rom_ctrl_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : rom_ctrl_rom_arb
// Description : Owner select for the single ROM read port. The integrity
//               checker owns the port from reset; after its done flag a
//               one-cycle handover drains its last read and the bus adapter
//               owns the port until reset. Loss of done or a corrupted
//               state parks the port and raises a sticky alert.
//               Macro ROM_CTRL_ARB_SPARSE_FSM_EN selects the sparse
//               (hardened) state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_ctrl_rom_arb
    import rom_ctrl_arb_pkg::*;
#(
    parameter int RomDepth  = 16,
    parameter int DW        = 32,
    parameter int StallCntW = STALL_CNT_W_DEFAULT,
    localparam int AW       = vbits(RomDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 chk_req_i,
    input  logic [AW-1:0]        chk_addr_i,
    input  logic                 chk_done_i,
    input  logic                 bus_req_i,
    input  logic [AW-1:0]        bus_addr_i,
    output logic                 bus_gnt_o,
    output logic                 bus_rvalid_o,
    output logic [DW-1:0]        bus_rdata_o,
    output logic                 rom_req_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [DW-1:0]        rom_rdata_i,
    output logic                 sel_bus_o,
    output logic                 alert_o,
    output logic [StallCntW-1:0] stall_cnt_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       rvalid_q;

    // Port mux and next-state logic; outputs follow the current state only.
    always_comb begin
        rom_req_o  = 1'b0;
        rom_addr_o = '0;
        bus_gnt_o  = 1'b0;
        state_d    = ARB_ERROR_ENC;
        unique case (state_q)
            ST_CHK_OWN: begin
                rom_req_o  = chk_req_i;
                rom_addr_o = chk_addr_i;
                state_d    = chk_done_i ? ST_HANDOVER : ST_CHK_OWN;
            end
            ST_HANDOVER: begin
                // Port idle for one cycle so the checker's final read returns.
                state_d = chk_done_i ? ST_BUS_OWN : ARB_ERROR_ENC;
            end
            ST_BUS_OWN: begin
                rom_req_o  = bus_req_i;
                rom_addr_o = bus_addr_i;
                bus_gnt_o  = bus_req_i;
                state_d    = chk_done_i ? ST_BUS_OWN : ARB_ERROR_ENC;
            end
            ST_ERROR: begin
                state_d = ARB_ERROR_ENC;
            end
            default: begin
                state_d = ARB_ERROR_ENC;
            end
        endcase
    end

    // Ownership state register; in the sparse build this is the hardened flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_CHK_OWN;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-valid tracks the grant one cycle later; reset drops any read in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus_gnt_o;
        end
    end

    assign bus_rvalid_o = rvalid_q;
    assign bus_rdata_o  = rvalid_q ? rom_rdata_i : '0;

    // Decode straight from the register; any value outside the three legal
    // operating states is treated as Error.
    assign sel_bus_o = (state_q == ST_BUS_OWN);
    assign alert_o   = !((state_q == ST_CHK_OWN)  ||
                         (state_q == ST_HANDOVER) ||
                         (state_q == ST_BUS_OWN));

    rom_ctrl_arb_stall_cnt #(
        .WIDTH (StallCntW)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .incr_i (bus_req_i & ~bus_gnt_o),
        .cnt_o  (stall_cnt_o)
    );

endmodule : rom_ctrl_rom_arb
`default_nettype wire

// File: tb/tb_rom_ctrl_rom_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_ctrl_rom_arb
// Description : Randomized self-checking bench for rom_ctrl_rom_arb against a
//               behavioural ownership model. The sparse-state corruption
//               scenario is built only with ROM_CTRL_ARB_SPARSE_FSM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_ctrl_rom_arb;
    import rom_ctrl_arb_pkg::*;

    localparam int RomDepth  = 16;
    localparam int DW        = 32;
    localparam int StallCntW = 8;
    localparam int AW        = 4;
    localparam int STALL_MAX = (1 << StallCntW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 chk_req, chk_done, bus_req;
    logic [AW-1:0]        chk_addr, bus_addr;
    logic [DW-1:0]        rom_rdata;
    logic                 bus_gnt, bus_rvalid, rom_req, sel_bus, alert;
    logic [DW-1:0]        bus_rdata;
    logic [AW-1:0]        rom_addr;
    logic [StallCntW-1:0] stall_cnt;

    always #5 clk = ~clk;

    rom_ctrl_rom_arb #(
        .RomDepth  (RomDepth),
        .DW        (DW),
        .StallCntW (StallCntW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .chk_req_i    (chk_req),
        .chk_addr_i   (chk_addr),
        .chk_done_i   (chk_done),
        .bus_req_i    (bus_req),
        .bus_addr_i   (bus_addr),
        .bus_gnt_o    (bus_gnt),
        .bus_rvalid_o (bus_rvalid),
        .bus_rdata_o  (bus_rdata),
        .rom_req_o    (rom_req),
        .rom_addr_o   (rom_addr),
        .rom_rdata_i  (rom_rdata),
        .sel_bus_o    (sel_bus),
        .alert_o      (alert),
        .stall_cnt_o  (stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ownership described by "cycles since done was first
    // seen" plus a sticky error flag, rather than by a state encoding.
    bit m_valid  = 1'b0;   // model meaningful once a reset edge has happened
    int m_since  = -1;     // -1: done not yet seen; 0: drain cycle; 1+: bus owns
    bit m_err    = 1'b0;
    bit m_rvalid = 1'b0;
    int m_stall  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic run_cycle(input bit rst_val, input bit creq, input logic [AW-1:0] caddr,
                             input bit done, input bit breq, input logic [AW-1:0] baddr,
                             input logic [DW-1:0] rdata);
        bit            e_req, e_gnt, e_checker, e_bus;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        rst_n     = rst_val;
        chk_req   = creq;
        chk_addr  = caddr;
        chk_done  = done;
        bus_req   = breq;
        bus_addr  = baddr;
        rom_rdata = rdata;
        #1;
        e_checker = !m_err && (m_since < 0);
        e_bus     = !m_err && (m_since >= 1);
        e_req     = e_checker ? creq : (e_bus ? breq : 1'b0);
        e_addr    = e_checker ? caddr : (e_bus ? baddr : '0);
        e_gnt     = e_bus && breq;
        if (m_valid) begin
            check_val("rom_req",    64'(rom_req),    64'(e_req));
            check_val("rom_addr",   64'(rom_addr),   64'(e_addr));
            check_val("bus_gnt",    64'(bus_gnt),    64'(e_gnt));
            check_val("bus_rvalid", 64'(bus_rvalid), 64'(m_rvalid));
            check_val("bus_rdata",  64'(bus_rdata),  m_rvalid ? 64'(rdata) : 64'd0);
            check_val("sel_bus",    64'(sel_bus),    64'(e_bus));
            check_val("alert",      64'(alert),      64'(m_err));
            check_val("stall_cnt",  64'(stall_cnt),  64'(m_stall));
        end
        @(posedge clk);
        if (!rst_val) begin
            m_valid  = 1'b1;
            m_since  = -1;
            m_err    = 1'b0;
            m_rvalid = 1'b0;
            m_stall  = 0;
        end else if (m_valid) begin
            m_rvalid = e_gnt;
            if (breq && !e_gnt && (m_stall < STALL_MAX)) m_stall++;
            if (!m_err) begin
                if (m_since < 0) begin
                    if (done) m_since = 0;
                end else if (!done) begin
                    m_err = 1'b1;
                end else if (m_since < 2) begin
                    m_since++;
                end
            end
        end
    endtask

    initial begin
        int n_chk;
        rst_n = 1'b0; chk_req = 1'b0; chk_addr = '0; chk_done = 1'b0;
        bus_req = 1'b0; bus_addr = '0; rom_rdata = '0;

        repeat (2) run_cycle(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 4'd2, $urandom);

        for (int round = 0; round < 3; round++) begin
            // Checker phase; first round holds bus_req long enough to saturate.
            run_cycle(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, AW'($urandom), $urandom);
            n_chk = (round == 0) ? 299 : int'($urandom_range(5, 20));
            for (int i = 0; i < n_chk; i++)
                run_cycle(1'b1, 1'($urandom), AW'($urandom), 1'b0,
                          (round == 0) ? 1'b1 : 1'($urandom), AW'($urandom), $urandom);

            // Done rises together with a checker request.
            run_cycle(1'b1, 1'b1, AW'($urandom), 1'b1, 1'b1, AW'($urandom), $urandom);

            if (round == 1) begin
                // Done lost during the drain cycle.
                run_cycle(1'b1, 1'b1, AW'($urandom), 1'b0, 1'b1, AW'($urandom), $urandom);
                for (int i = 0; i < 15; i++)
                    run_cycle(1'b1, 1'($urandom), AW'($urandom), 1'($urandom),
                              1'($urandom), AW'($urandom), $urandom);
            end else begin
                // Drain cycle, then a directed bus read and its data return.
                run_cycle(1'b1, 1'b1, AW'($urandom), 1'b1, 1'b1, 4'd3, $urandom);
                run_cycle(1'b1, 1'b0, AW'($urandom), 1'b1, 1'b1, 4'd3, $urandom);
                run_cycle(1'b1, 1'b0, AW'($urandom), 1'b1, 1'b0, AW'($urandom), 32'hDEADBEEF);
                for (int i = 0; i < 100; i++)
                    run_cycle(1'b1, 1'($urandom), AW'($urandom), 1'b1,
                              1'($urandom), AW'($urandom), $urandom);
                if (round == 0) begin
                    // Done lost while the bus owns the port, with a grant in flight.
                    run_cycle(1'b1, 1'b1, AW'($urandom), 1'b0, 1'b1, AW'($urandom), $urandom);
                    for (int i = 0; i < 20; i++)
                        run_cycle(1'b1, 1'($urandom), AW'($urandom), 1'($urandom),
                                  1'($urandom), AW'($urandom), $urandom);
                end else begin
                    // Reset lands while a granted read is in flight.
                    run_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, 1'b1, AW'($urandom), $urandom);
                end
            end

            repeat (2) run_cycle(1'b0, 1'($urandom), AW'($urandom), 1'b0,
                                 1'($urandom), AW'($urandom), $urandom);
        end

        run_cycle(1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0, $urandom);

`ifdef ROM_CTRL_ARB_SPARSE_FSM_EN
        // Corrupt the state register with an unlisted value.
        @(negedge clk);
        chk_req  = 1'b1;
        chk_done = 1'b0;
        bus_req  = 1'b0;
        force dut.state_q = arb_state_e'(6'h3F);
        #1;
        check_val("sparse_alert_decode", 64'(alert),   64'd1);
        check_val("sparse_req_parked",   64'(rom_req), 64'd0);
        release dut.state_q;
        @(posedge clk);
        m_err    = 1'b1;
        m_rvalid = 1'b0;
        repeat (3) run_cycle(1'b1, 1'b1, AW'($urandom), 1'b1, 1'($urandom), AW'($urandom), $urandom);
        repeat (2) run_cycle(1'b0, 1'b1, AW'($urandom), 1'b0, 1'b0, AW'($urandom), $urandom);
        run_cycle(1'b1, 1'b1, AW'($urandom), 1'b0, 1'b0, AW'($urandom), $urandom);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rom_ctrl_rom_arb
`default_nettype wire

// File: doc/rom_ctrl_rom_arb.md
# rom_ctrl_rom_arb

Arbiter and owner-select for the single ROM read port in rom_ctrl. After reset it gives the port exclusively to the integrity checker (the address counter driving KMAC). Once the checker signals done, it drains the checker's last read, hands the port to the bus-side TL adapter, and keeps it there until reset. Any loss of the checker's done indication, or any corruption of the ownership state, parks the port and raises an alert.

## Interface
Parameters:
- RomDepth, 16, number of ROM words; AW = vbits(RomDepth).
- DW, 32, ROM data width.
- StallCntW, 8, width of the bus stall counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, synchronous and active-low.
- chk_req_i  in  1  checker read request.
- chk_addr_i  in  AW  checker read address.
- chk_done_i  in  1  checker finished; must never fall once high.
- bus_req_i  in  1  bus read request.
- bus_addr_i  in  AW  bus read address.
- bus_gnt_o  out  1  bus request accepted this cycle.
- bus_rvalid_o  out  1  bus read data valid.
- bus_rdata_o  out  DW  bus read data.
- rom_req_o  out  1  ROM read request.
- rom_addr_o  out  AW  ROM read address.
- rom_rdata_i  in  DW  ROM data, valid one cycle after rom_req_o.
- sel_bus_o  out  1  bus owns the ROM port.
- alert_o  out  1  fatal arbitration error, sticky.
- stall_cnt_o  out  StallCntW  saturating count of stalled bus cycles.

## Operation
- The state register has four states: ChkOwn, Handover, BusOwn, Error. The reset state is ChkOwn.
- ChkOwn:
  - rom_req_o = chk_req_i, rom_addr_o = chk_addr_i, bus_gnt_o = 0.
  - If chk_done_i = 1, go to Handover.
- Handover (exactly one cycle):
  - rom_req_o = 0, rom_addr_o = 0, bus_gnt_o = 0. This lets the checker's final read return.
  - If chk_done_i = 0, go to Error; otherwise go to BusOwn.
- BusOwn:
  - rom_req_o = bus_req_i, rom_addr_o = bus_addr_i, bus_gnt_o = bus_req_i.
  - If chk_done_i = 0, go to Error; otherwise stay in BusOwn.
- Error:
  - rom_req_o = 0, rom_addr_o = 0, bus_gnt_o = 0.
  - Terminal; only reset leaves it.
- Any unencoded state value goes to Error on the next edge.
- sel_bus_o = (state == BusOwn), decoded from the state register.
- alert_o = (state == Error), decoded from the state register.
- Read return path:
  - bus_rvalid_o is a register loaded with bus_gnt_o every cycle.
  - bus_rdata_o = rom_rdata_i when bus_rvalid_o = 1, else 0.
  - A grant issued in the cycle before entering Error still returns its data.
- Stall counter:
  - stall_cnt_o increments by 1 each cycle with bus_req_i = 1 and bus_gnt_o = 0.
  - It saturates at 2^StallCntW - 1 and does not wrap.
  - Only reset clears it.
- Simultaneous events: chk_req_i asserted in the same cycle chk_done_i rises is still forwarded. In ChkOwn the outputs depend on the current state, not the next state.

## Timing
- Reset values, while rst_ni is low and in the first cycle after release:
  - state = ChkOwn, so rom_req_o = chk_req_i and rom_addr_o = chk_addr_i.
  - bus_gnt_o = 0, bus_rvalid_o = 0, bus_rdata_o = 0, sel_bus_o = 0, alert_o = 0, stall_cnt_o = 0.
- chk_done_i rises at edge N: state is Handover in cycle N+1 and BusOwn in cycle N+2. The first possible bus_gnt_o is in cycle N+2.
- Grant in cycle G gives bus_rvalid_o = 1 in cycle G+1, carrying rom_rdata_i of G+1.
- chk_done_i falls while in Handover or BusOwn: alert_o = 1 and rom_req_o = 0 from the next cycle on. A pending bus_req_i is then never granted.
- Reset asserted mid-operation: takes effect on the next edge and returns ownership to the checker. A read in flight at that point is dropped; bus_rvalid_o is 0 after the edge.
- Grant and data paths: bus_gnt_o is combinational from bus_req_i and state. The path from rom_rdata_i to bus_rdata_o is combinational.

## Configuration
- Macro ROM_CTRL_ARB_SPARSE_FSM_EN controls the state encoding.
- Defined:
  - State is a 6-bit sparse encoding with pairwise Hamming distance ≥ 3, held in a hardened flop.
  - Every non-listed value decodes to Error and drives alert_o.
- Undefined:
  - State is plain 2-bit binary: ChkOwn = 0, Handover = 1, BusOwn = 2, Error = 3.
  - All other functional behaviour is identical.

## Structure
- Package rom_ctrl_arb_pkg holds:
  - the state enum, with both encodings selected by the macro;
  - StallCntW's default;
  - the constant for the Error encoding.
- One sub-module, rom_ctrl_arb_stall_cnt, implements the saturating stall counter.
- All state decode stays in the top module.

## Test plan
- Reset, then chk_req_i = 1 and chk_addr_i = 5 → rom_req_o = 1, rom_addr_o = 5, bus_gnt_o = 0, sel_bus_o = 0.
- chk_done_i rises at edge 10 → Handover in cycle 11 with rom_req_o = 0; sel_bus_o = 1 and bus_gnt_o = bus_req_i in cycle 12.
- In BusOwn, bus_req_i = 1, bus_addr_i = 3, rom_rdata_i = 0xDEADBEEF in the next cycle → bus_rvalid_o = 1 and bus_rdata_o = 0xDEADBEEF one cycle after the grant.
- bus_req_i held high for 300 cycles before done, StallCntW = 8 → stall_cnt_o = 255 and stays there.
- chk_done_i drops in BusOwn → alert_o = 1 and rom_req_o = 0 next cycle; both stay until reset; reset restores ChkOwn with alert_o = 0.
- With ROM_CTRL_ARB_SPARSE_FSM_EN defined, force an invalid state value → Error next cycle with alert_o = 1.
